pru_cmd_queue: RTL and testbench

Command front-end for the PRU (pixel render unit). Buffers draw commands (rectangle, circle, bitmap) issued by the CPU-side bus. Sequences them one at a time into the PRU through its start/busy/done handshake. Holds every shape parameter stable on the PRU inputs for the whole operation, so software can post several shapes back-to-back without polling the PRU.

---
 rtl/pru_pkg.sv | 35 +++
 rtl/pru_cmd_queue_if.sv | 27 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/pru_cmd_queue.sv | 132 +++++++++++++
 tb/tb_pru_cmd_queue.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pru_pkg.sv
// Shared PRU types: shape encoding, packed draw command and command-queue FSM states.
// Used by the PRU, the bus decoder and the command queue.
package pru_pkg;

  typedef enum logic [1:0] {
    RECT   = 2'd0,
    CIRCLE = 2'd1,
    BITMAP = 2'd2,
    RSVD   = 2'd3
  } shape_e;

  typedef struct packed {
    logic [1:0]  color;
    logic [9:0]  row;
    logic [8:0]  col;
    logic [9:0]  width;
    logic [8:0]  height_radius;
    logic [31:0] bitmap_addr;
    shape_e      shape;
    logic        subtract;
  } pru_cmd_t;

  localparam int PRU_CMD_W = $bits(pru_cmd_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } cmd_q_state_e;

  function automatic logic is_reserved(shape_e s);
    return s == RSVD;
  endfunction

endpackage

// File: rtl/pru_cmd_queue_if.sv
// CPU-side command bus into the PRU command queue: valid/ready handshake plus command fields.
interface pru_cmd_queue_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_color;
  logic [9:0]  cmd_row;
  logic [8:0]  cmd_col;
  logic [9:0]  cmd_width;
  logic [8:0]  cmd_height_radius;
  logic [31:0] cmd_bitmap_addr;
  logic [1:0]  cmd_shape;
  logic        cmd_subtract;

  modport master (
    output cmd_valid, cmd_color, cmd_row, cmd_col, cmd_width,
           cmd_height_radius, cmd_bitmap_addr, cmd_shape, cmd_subtract,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_color, cmd_row, cmd_col, cmd_width,
           cmd_height_radius, cmd_bitmap_addr, cmd_shape, cmd_subtract,
    output cmd_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flush clears it and overrides push/pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pru_cmd_queue.sv
// PRU command front-end: buffers draw commands and issues them one at a time over the
// PRU start/busy/done handshake, holding parameters stable for the whole operation.
module pru_cmd_queue
  import pru_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  pru_cmd_queue_if.slave             cmd_bus,
  input  logic                       flush,
  output logic [1:0]                 color,
  output logic [9:0]                 row,
  output logic [8:0]                 col,
  output logic [9:0]                 width,
  output logic [8:0]                 height_radius,
  output logic [31:0]                bitmap_addr,
  output logic [1:0]                 shape_select,
  output logic                       subtract,
  output logic                       start,
  input  logic                       busy,
  input  logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       idle,
  output logic [15:0]                done_count,
  output logic                       bad_cmd
);

  pru_cmd_t               cmd_in;
  pru_cmd_t               head;
  logic [PRU_CMD_W-1:0]   head_raw;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop;

  cmd_q_state_e           state_q;
  pru_cmd_t               param_q;
  logic                   start_q;
  logic [15:0]            done_cnt_q;
  logic                   bad_cmd_q;

  always_comb begin
    cmd_in.color         = cmd_bus.cmd_color;
    cmd_in.row           = cmd_bus.cmd_row;
    cmd_in.col           = cmd_bus.cmd_col;
    cmd_in.width         = cmd_bus.cmd_width;
    cmd_in.height_radius = cmd_bus.cmd_height_radius;
    cmd_in.bitmap_addr   = cmd_bus.cmd_bitmap_addr;
    cmd_in.shape         = shape_e'(cmd_bus.cmd_shape);
    cmd_in.subtract      = cmd_bus.cmd_subtract;
  end

  // Ready looks only at registered fullness and flush: a same-cycle pop never frees a slot.
  assign cmd_bus.cmd_ready = !fifo_full && !flush;
  assign push              = cmd_bus.cmd_valid && cmd_bus.cmd_ready;
  assign pop               = (state_q == IDLE) && !fifo_empty && !flush;
  assign head              = pru_cmd_t'(head_raw);

  sync_fifo #(
    .WIDTH (PRU_CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (cmd_in),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (queue_count)
  );

  // Flush only clears the queue; an operation already in ISSUE/RUN runs to completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      param_q    <= '0;
      start_q    <= 1'b0;
      done_cnt_q <= '0;
      bad_cmd_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            if (is_reserved(head.shape)) begin
              bad_cmd_q <= 1'b1;
            end else begin
              param_q <= head;
              start_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (done) begin
            start_q    <= 1'b0;
            done_cnt_q <= done_cnt_q + 16'd1;
            state_q    <= IDLE;
          end else if (busy) begin
            start_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (done) begin
            done_cnt_q <= done_cnt_q + 16'd1;
            state_q    <= IDLE;
          end
        end
        default: begin
          start_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign color         = param_q.color;
  assign row           = param_q.row;
  assign col           = param_q.col;
  assign width         = param_q.width;
  assign height_radius = param_q.height_radius;
  assign bitmap_addr   = param_q.bitmap_addr;
  assign shape_select  = param_q.shape;
  assign subtract      = param_q.subtract;
  assign start         = start_q;
  assign done_count    = done_cnt_q;
  assign bad_cmd       = bad_cmd_q;
  assign idle          = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_pru_cmd_queue.sv
// Scoreboard bench for pru_cmd_queue: accepted commands queue their expected PRU
// parameters; a negedge monitor compares them on every rising start.
module tb_pru_cmd_queue;
  import pru_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          busy = 1'b0;
  logic          done = 1'b0;
  logic [1:0]    color;
  logic [9:0]    row;
  logic [8:0]    col;
  logic [9:0]    width;
  logic [8:0]    height_radius;
  logic [31:0]   bitmap_addr;
  logic [1:0]    shape_select;
  logic          subtract;
  logic          start;
  logic [CW-1:0] queue_count;
  logic          idle;
  logic [15:0]   done_count;
  logic          bad_cmd;

  pru_cmd_queue_if cmd_if ();

  pru_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_bus       (cmd_if),
    .flush         (flush),
    .color         (color),
    .row           (row),
    .col           (col),
    .width         (width),
    .height_radius (height_radius),
    .bitmap_addr   (bitmap_addr),
    .shape_select  (shape_select),
    .subtract      (subtract),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .queue_count   (queue_count),
    .idle          (idle),
    .done_count    (done_count),
    .bad_cmd       (bad_cmd)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_pass = 0;
  int        start_rises = 0;
  int        ops_finished = 0;
  int        exp_done = 0;
  logic      start_prev = 1'b0;
  pru_cmd_t  exp_q[$];
  pru_cmd_t  mon_exp;
  pru_cmd_t  drv_cmd;
  pru_cmd_t  dut_params;

  always_comb dut_params = {color, row, col, width, height_radius, bitmap_addr, shape_select, subtract};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_cmd(input string name, input pru_cmd_t act, input pru_cmd_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic pru_cmd_t mk(input int c, input int r, input int cl, input int w,
                                  input int h, input int addr, input int s, input int sub);
    pru_cmd_t x;
    x.color         = 2'(c);
    x.row           = 10'(r);
    x.col           = 9'(cl);
    x.width         = 10'(w);
    x.height_radius = 9'(h);
    x.bitmap_addr   = 32'(addr);
    x.shape         = shape_e'(2'(s));
    x.subtract      = 1'(sub);
    return x;
  endfunction

  // Monitor: every new start pulse must present the oldest outstanding accepted command.
  always @(negedge clk) begin
    if (rst) begin
      start_prev = 1'b0;
    end else begin
      if (start && !start_prev) begin
        start_rises++;
        if (exp_q.size() == 0) begin
          check("start_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_exp = exp_q.pop_front();
          check_cmd("issue_params", dut_params, mon_exp);
        end
      end
      start_prev = start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input pru_cmd_t c);
    drv_cmd                  = c;
    cmd_if.cmd_valid         = 1'b1;
    cmd_if.cmd_color         = c.color;
    cmd_if.cmd_row           = c.row;
    cmd_if.cmd_col           = c.col;
    cmd_if.cmd_width         = c.width;
    cmd_if.cmd_height_radius = c.height_radius;
    cmd_if.cmd_bitmap_addr   = c.bitmap_addr;
    cmd_if.cmd_shape         = c.shape;
    cmd_if.cmd_subtract      = c.subtract;
  endtask

  task automatic accept_cmd(input int budget);
    int waited = 0;
    while (!cmd_if.cmd_ready && waited < budget) begin
      tick();
      waited++;
    end
    if (!cmd_if.cmd_ready) check("accept_wait", 32'(cmd_if.cmd_ready), 32'd1);
    else if (drv_cmd.shape != RSVD) exp_q.push_back(drv_cmd);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic push_cmd(input pru_cmd_t c);
    drive_cmd(c);
    accept_cmd(20);
  endtask

  // Wait until the next outstanding operation has been issued and start has dropped.
  task automatic wait_run();
    int w = 0;
    while ((start_rises <= ops_finished || start) && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check("op_wait", 32'(w), 32'd0);
  endtask

  task automatic complete_op();
    wait_run();
    done = 1'b1;
    tick();
    done = 1'b0;
    ops_finished++;
    exp_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    pru_cmd_t r1, ra, circ, c10, d, e, extra;
    int rises0;

    cmd_if.cmd_valid = 1'b0;
    drive_cmd(mk(0, 0, 0, 0, 0, 0, 0, 0));
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_start", 32'(start), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("rst_count", 32'(queue_count), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_done_count", 32'(done_count), 32'd0);
    check("rst_bad_cmd", 32'(bad_cmd), 32'd0);
    check_cmd("rst_params", dut_params, '0);

    // Single rectangle: start and parameters one edge after the push
    r1 = mk(1, 10, 10, 15, 15, 0, 0, 0);
    push_cmd(r1);
    check("t1_count_after_push", 32'(queue_count), 32'd1);
    check("t1_no_start_yet", 32'(start), 32'd0);
    tick();
    check("t1_start", 32'(start), 32'd1);
    check_cmd("t1_params", dut_params, r1);
    check("t1_count_popped", 32'(queue_count), 32'd0);
    tick();
    check("t1_start_held", 32'(start), 32'd1);
    busy = 1'b1;
    tick();
    check("t1_start_dropped", 32'(start), 32'd0);
    tick();
    busy = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_done++;
    ops_finished++;
    check("t1_done_count", 32'(done_count), 32'(exp_done));
    check("t1_idle", 32'(idle), 32'd1);

    // Fill the queue behind a stalled PRU; the tenth command waits for a pop
    busy = 1'b1;
    for (int i = 0; i < 9; i++) push_cmd(mk(i, 100 + i, 50 + i, 20 + i, 5 + i, 32'h1000_0000 + i, i % 3, i % 2));
    check("t2_full_count", 32'(queue_count), 32'd8);
    check("t2_full_not_ready", 32'(cmd_if.cmd_ready), 32'd0);
    c10 = mk(3, 777, 333, 555, 222, 32'h0BAD_F00D, 2, 1);
    drive_cmd(c10);
    tick();
    tick();
    check("t2_held_count", 32'(queue_count), 32'd8);
    complete_op();
    accept_cmd(20);
    check("t2_refill_count", 32'(queue_count), 32'd8);
    repeat (9) complete_op();
    check("t2_done_count", 32'(done_count), 32'(exp_done));
    check("t2_idle", 32'(idle), 32'd1);

    // Circle queued behind a running rectangle; one idle cycle between operations
    ra = mk(3, 200, 100, 40, 30, 0, 0, 1);
    circ = mk(2, 30, 30, 0, 10, 0, 1, 0);
    push_cmd(ra);
    wait_run();
    push_cmd(circ);
    check("t3_count", 32'(queue_count), 32'd1);
    check("t3_no_start", 32'(start), 32'd0);
    tick();
    tick();
    check_cmd("t3_params_hold", dut_params, ra);
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_done++;
    ops_finished++;
    check("t3_gap_start_low", 32'(start), 32'd0);
    check_cmd("t3_gap_params", dut_params, ra);
    check("t3_done_count", 32'(done_count), 32'(exp_done));
    tick();
    check("t3_circle_start", 32'(start), 32'd1);
    check_cmd("t3_circle_params", dut_params, circ);
    complete_op();

    // Reserved shape between two valid commands is discarded
    check("t4_bad_before", 32'(bad_cmd), 32'd0);
    rises0 = start_rises;
    push_cmd(mk(0, 1, 2, 3, 4, 0, 0, 0));
    push_cmd(mk(1, 5, 6, 7, 8, 32'h0000_DEAD, 3, 0));
    push_cmd(mk(2, 9, 10, 0, 11, 32'h2000_0040, 2, 1));
    complete_op();
    complete_op();
    check("t4_start_pulses", 32'(start_rises - rises0), 32'd2);
    check("t4_bad_cmd", 32'(bad_cmd), 32'd1);
    check("t4_done_count", 32'(done_count), 32'(exp_done));
    check("t4_count", 32'(queue_count), 32'd0);

    // Done in the first ISSUE cycle with no busy; maximum field values
    busy = 1'b0;
    d = mk(1, 1023, 511, 1023, 511, 32'hFFFF_FFFF, 1, 1);
    push_cmd(d);
    tick();
    check("t5_start", 32'(start), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_done++;
    ops_finished++;
    check("t5_start_low", 32'(start), 32'd0);
    check("t5_done_count", 32'(done_count), 32'(exp_done));
    check("t5_idle", 32'(idle), 32'd1);
    tick();
    check("t5_done_once", 32'(done_count), 32'(exp_done));
    check("t5_scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Flush with five queued and one running; a same-cycle push is dropped
    busy = 1'b1;
    for (int i = 0; i < 6; i++) push_cmd(mk(i, 300 + i, 7 * i, 9 + i, 3 + i, 32'h4000_0000 + i, i % 3, 0));
    check("t6_count_before", 32'(queue_count), 32'd5);
    extra = mk(2, 44, 44, 44, 44, 0, 0, 0);
    drive_cmd(extra);
    flush = 1'b1;
    #1;
    check("t6_flush_not_ready", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    flush = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    exp_q.delete();
    check("t6_count_flushed", 32'(queue_count), 32'd0);
    check("t6_not_idle_in_run", 32'(idle), 32'd0);
    rises0 = start_rises;
    complete_op();
    check("t6_done_count", 32'(done_count), 32'(exp_done));
    check("t6_idle", 32'(idle), 32'd1);
    repeat (4) tick();
    check("t6_no_more_start", 32'(start_rises - rises0), 32'd0);

    // Reset asserted during ISSUE drops start without waiting for a clock edge
    busy = 1'b0;
    e = mk(2, 12, 34, 56, 78, 32'h0000_1234, 0, 1);
    push_cmd(e);
    tick();
    check("t7_start_issue", 32'(start), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t7_rst_start", 32'(start), 32'd0);
    check_cmd("t7_rst_params", dut_params, '0);
    check("t7_rst_count", 32'(queue_count), 32'd0);
    check("t7_rst_idle", 32'(idle), 32'd1);
    check("t7_rst_done_count", 32'(done_count), 32'd0);
    check("t7_rst_bad_cmd", 32'(bad_cmd), 32'd0);
    check("t7_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
